intwb_arbiter: RTL and testbench
================================

Name: intwb_arbiter

Overview:
- Shares the single integer writeback slot between the ALU/BJU block (source A) and the multi-cycle MUL/DIV unit (source M).
- Also acts as the registered intwb pipeline stage: the winner is captured and driven to regfile/ROB/redirect logic one cycle later.
- Fixed priority to A, with a starvation counter that forces a grant to M.
- Requests younger than an incoming flush are dropped without consuming the slot.

Parameters:
- PREG_W, 6, physical register index width.
- ROB_IDX_W, `ROB_SIZE_LOG+1, ROB id width; MSB is the wrap bit.
- STARVE_LIMIT, 4, number of consecutive cycles M may lose before it is forced to win.
- CNT_W, 3, starvation counter width; must hold STARVE_LIMIT.

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- a_valid  in  1  source A request
- a_ready  out  1  source A accepted this cycle
- a_need_to_wb  in  1  A writes a preg
- a_prd  in  PREG_W  A destination preg
- a_result  in  64  A result
- a_redirect_valid  in  1  A mispredict/redirect
- a_redirect_target  in  64  A redirect PC
- a_robid  in  ROB_IDX_W  A rob id
- m_valid  in  1  source M request
- m_ready  out  1  source M accepted this cycle
- m_need_to_wb  in  1  M writes a preg
- m_prd  in  PREG_W  M destination preg
- m_result  in  64  M result
- m_robid  in  ROB_IDX_W  M rob id
- flush_valid  in  1  backend flush this cycle
- flush_robid  in  ROB_IDX_W  rob id of the flushing instruction
- wb_valid  out  1  registered writeback valid
- wb_src  out  1  0 = A, 1 = M
- wb_need_to_wb  out  1  registered
- wb_prd  out  PREG_W  registered
- wb_result  out  64  registered
- wb_redirect_valid  out  1  registered; 0 when wb_src = M
- wb_redirect_target  out  64  registered
- wb_robid  out  ROB_IDX_W  registered
- starve_cnt  out  CNT_W  debug view of the counter

Behaviour:
- Reset: clock is single; reset_n is asynchronous and active-low. All registered outputs and starve_cnt reset to 0.
- Age function: younger(x,f) = (x.msb == f.msb) ? (x.low > f.low) : (x.low < f.low). Equal ids are not younger.
- Kill conditions:
  - a_kill = flush_valid & younger(a_robid, flush_robid).
  - m_kill is defined the same way using m_robid.
- Effective requests: ea = a_valid & ~a_kill; em = m_valid & ~m_kill.
- Forcing: force_m = (starve_cnt == STARVE_LIMIT) & em.
- Grants:
  - grant_m = em & (force_m | ~ea).
  - grant_a = ea & ~grant_m.
- Ready outputs (combinational from valid, flush and counter; no combinational path from wb_*):
  - a_ready = grant_a | a_kill | ~a_valid.
  - m_ready = grant_m | m_kill | ~m_valid.
  - Killed requests are consumed and dropped.
- Output register: latency 1 from grant to wb_valid.
  - wb_valid <= grant_a | grant_m.
  - On a grant, payload registers load the winner's fields and wb_src is set.
  - For M: wb_redirect_valid <= 0 and wb_redirect_target <= 0.
  - With no grant, wb_valid <= 0, wb_redirect_valid <= 0, and the remaining payload holds its value.
- Starvation counter:
  - Increments by 1 when em & ~grant_m, saturating at STARVE_LIMIT.
  - Clears to 0 when grant_m or ~em.
  - A killed M request counts as absent.
- Flush vs registered output: the entry already in wb_* is never squashed. The flush source is downstream of this stage, so that entry is the flusher or older.
- Simultaneous A and M both killed: no grant, wb_valid <= 0 next cycle, both readies 1.
- Requester contract: A and M must hold valid and payload stable until ready. Violations are a checker error.
- Asserting reset_n low mid-stream clears wb_valid immediately (asynchronously). An in-flight request is lost; upstream reset covers it.

Decomposition:
- Shared package intwb_pkg:
  - intwb_req_t struct (need_to_wb, prd, result, redirect_valid, redirect_target, robid).
  - Function rob_younger(x, f).
  - Constant STARVE_LIMIT default.
- Sub-module rob_age_cmp: combinational younger compare. It is reused by the ROB, LSQ flush and this block, instantiated twice here.

Test Plan:
- A-only priority:
  - a_valid=1 (robid 5, prd 12, result 0xDEAD) and m_valid=0 → a_ready=1.
  - Next cycle wb_valid=1, wb_src=0, wb_prd=12, wb_result=0xDEAD.
- Contention and starvation:
  - a_valid and m_valid held high for 6 cycles.
  - Cycles 0–3: A wins, starve_cnt counts 1, 2, 3, 4.
  - Cycle 4: m_ready=1, a_ready=0, wb_src=1 next cycle, counter returns to 0.
- Flush kill of A:
  - flush_valid=1, flush_robid=10, a_robid=12, m_robid=8, both valid.
  - a_ready=1 (dropped), M granted, wb_src=1, wb_robid=8.
- Wrap-around age:
  - flush_robid = {1,3}; a_robid = {0,60} (older across wrap) and m_robid = {1,5} (younger).
  - A granted, M killed, m_ready=1.
- Redirect pass-through and M masking:
  - A wins with redirect_valid=1, target 0x8000_1000 → registered with wb_src=0.
  - Next M grant shows wb_redirect_valid=0.
- Reset mid-stream:
  - wb_valid=1 and starve_cnt=3; pulse reset_n low between clock edges.
  - wb_valid and starve_cnt are 0 immediately, before the next edge.

Source files
------------

// File: rtl/intwb_pkg.sv
// Shared types and constants for the integer writeback arbiter.
// Also provides the ROB age helper used by neighbouring blocks.
package intwb_pkg;
  localparam int ROB_SIZE_LOG         = 6;
  localparam int INTWB_PREG_W         = 6;
  localparam int INTWB_ROB_IDX_W      = ROB_SIZE_LOG + 1;
  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int DEFAULT_CNT_W        = 3;

  typedef struct packed {
    logic                         need_to_wb;
    logic [INTWB_PREG_W-1:0]      prd;
    logic [63:0]                  result;
    logic                         redirect_valid;
    logic [63:0]                  redirect_target;
    logic [INTWB_ROB_IDX_W-1:0]   robid;
  } intwb_req_t;

  // The MSB is the wrap bit: a differing wrap bit inverts the low-part comparison.
  function automatic logic rob_younger(input logic [INTWB_ROB_IDX_W-1:0] x,
                                       input logic [INTWB_ROB_IDX_W-1:0] f);
    if (x[INTWB_ROB_IDX_W-1] == f[INTWB_ROB_IDX_W-1])
      return x[INTWB_ROB_IDX_W-2:0] > f[INTWB_ROB_IDX_W-2:0];
    else
      return x[INTWB_ROB_IDX_W-2:0] < f[INTWB_ROB_IDX_W-2:0];
  endfunction
endpackage

// File: rtl/rob_age_cmp.sv
// Combinational ROB age compare: younger=1 when x is strictly younger than f.
// Width-generic so the ROB, LSQ flush and writeback arbiter can share it.
module rob_age_cmp #(
  parameter int W = 7
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] f,
  output logic         younger
);
  assign younger = (x[W-1] == f[W-1]) ? (x[W-2:0] > f[W-2:0])
                                      : (x[W-2:0] < f[W-2:0]);
endmodule

// File: rtl/intwb_arbiter.sv
// Integer writeback slot arbiter and registered intwb stage: A has fixed
// priority, M is forced through after STARVE_LIMIT consecutive losses.
module intwb_arbiter
  import intwb_pkg::*;
#(
  parameter int PREG_W       = INTWB_PREG_W,
  parameter int ROB_IDX_W    = INTWB_ROB_IDX_W,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic                 a_need_to_wb,
  input  logic [PREG_W-1:0]    a_prd,
  input  logic [63:0]          a_result,
  input  logic                 a_redirect_valid,
  input  logic [63:0]          a_redirect_target,
  input  logic [ROB_IDX_W-1:0] a_robid,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic                 m_need_to_wb,
  input  logic [PREG_W-1:0]    m_prd,
  input  logic [63:0]          m_result,
  input  logic [ROB_IDX_W-1:0] m_robid,
  input  logic                 flush_valid,
  input  logic [ROB_IDX_W-1:0] flush_robid,
  output logic                 wb_valid,
  output logic                 wb_src,
  output logic                 wb_need_to_wb,
  output logic [PREG_W-1:0]    wb_prd,
  output logic [63:0]          wb_result,
  output logic                 wb_redirect_valid,
  output logic [63:0]          wb_redirect_target,
  output logic [ROB_IDX_W-1:0] wb_robid,
  output logic [CNT_W-1:0]     starve_cnt
);
  logic [ROB_IDX_W-1:0] src_robid [2];
  logic [1:0]           kill;

  assign src_robid[0] = a_robid;
  assign src_robid[1] = m_robid;

  // Index 0 is source A, index 1 is source M.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_age
      logic younger;
      rob_age_cmp #(.W(ROB_IDX_W)) u_age_cmp (
        .x       (src_robid[gi]),
        .f       (flush_robid),
        .younger (younger)
      );
      assign kill[gi] = flush_valid & younger;
    end
  endgenerate

  logic ea, em, force_m, grant_a, grant_m;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic       valid_reg, valid_next;
  logic       src_reg, src_next;
  intwb_req_t payload_reg, payload_next;
  intwb_req_t a_req, m_req;

  assign ea      = a_valid & ~kill[0];
  assign em      = m_valid & ~kill[1];
  assign force_m = (cnt_reg == CNT_W'(STARVE_LIMIT)) & em;
  assign grant_m = em & (force_m | ~ea);
  assign grant_a = ea & ~grant_m;

  // Killed requests are acknowledged so the requester drops them.
  assign a_ready = grant_a | kill[0] | ~a_valid;
  assign m_ready = grant_m | kill[1] | ~m_valid;

  always_comb begin
    a_req                 = '0;
    a_req.need_to_wb      = a_need_to_wb;
    a_req.prd             = a_prd;
    a_req.result          = a_result;
    a_req.redirect_valid  = a_redirect_valid;
    a_req.redirect_target = a_redirect_target;
    a_req.robid           = a_robid;

    m_req                 = '0;
    m_req.need_to_wb      = m_need_to_wb;
    m_req.prd             = m_prd;
    m_req.result          = m_result;
    m_req.robid           = m_robid;
  end

  always_comb begin
    valid_next   = grant_a | grant_m;
    src_next     = src_reg;
    payload_next = payload_reg;
    if (grant_m) begin
      src_next     = 1'b1;
      payload_next = m_req;
    end else if (grant_a) begin
      src_next     = 1'b0;
      payload_next = a_req;
    end else begin
      payload_next.redirect_valid = 1'b0;
    end
  end

  always_comb begin
    cnt_next = '0;
    if (em & ~grant_m) begin
      if (cnt_reg < CNT_W'(STARVE_LIMIT))
        cnt_next = cnt_reg + CNT_W'(1);
      else
        cnt_next = cnt_reg;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg   <= 1'b0;
      src_reg     <= 1'b0;
      payload_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      valid_reg   <= valid_next;
      src_reg     <= src_next;
      payload_reg <= payload_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign wb_valid           = valid_reg;
  assign wb_src             = src_reg;
  assign wb_need_to_wb      = payload_reg.need_to_wb;
  assign wb_prd             = payload_reg.prd;
  assign wb_result          = payload_reg.result;
  assign wb_redirect_valid  = payload_reg.redirect_valid;
  assign wb_redirect_target = payload_reg.redirect_target;
  assign wb_robid           = payload_reg.robid;
  assign starve_cnt         = cnt_reg;
endmodule

// File: tb/tb_intwb_arbiter.sv
// Self-checking bench for intwb_arbiter: directed scenarios plus randomized
// traffic against a modular-arithmetic reference model.
module tb_intwb_arbiter;
  localparam int PREG_W = 6;
  localparam int RW     = 7;
  localparam int LIMIT  = 4;
  localparam int CW     = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic a_valid = 0, a_need_to_wb = 0, a_redirect_valid = 0;
  logic [PREG_W-1:0] a_prd = '0;
  logic [63:0] a_result = '0, a_redirect_target = '0;
  logic [RW-1:0] a_robid = '0;
  logic m_valid = 0, m_need_to_wb = 0;
  logic [PREG_W-1:0] m_prd = '0;
  logic [63:0] m_result = '0;
  logic [RW-1:0] m_robid = '0;
  logic flush_valid = 0;
  logic [RW-1:0] flush_robid = '0;
  logic a_ready, m_ready, wb_valid, wb_src, wb_need_to_wb, wb_redirect_valid;
  logic [PREG_W-1:0] wb_prd;
  logic [63:0] wb_result, wb_redirect_target;
  logic [RW-1:0] wb_robid;
  logic [CW-1:0] starve_cnt;

  intwb_arbiter dut (
    .clock(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_need_to_wb(a_need_to_wb),
    .a_prd(a_prd), .a_result(a_result), .a_redirect_valid(a_redirect_valid),
    .a_redirect_target(a_redirect_target), .a_robid(a_robid),
    .m_valid(m_valid), .m_ready(m_ready), .m_need_to_wb(m_need_to_wb),
    .m_prd(m_prd), .m_result(m_result), .m_robid(m_robid),
    .flush_valid(flush_valid), .flush_robid(flush_robid),
    .wb_valid(wb_valid), .wb_src(wb_src), .wb_need_to_wb(wb_need_to_wb),
    .wb_prd(wb_prd), .wb_result(wb_result), .wb_redirect_valid(wb_redirect_valid),
    .wb_redirect_target(wb_redirect_target), .wb_robid(wb_robid),
    .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          exp_cnt = 0;
  bit          exp_valid = 0, exp_src = 0, exp_ntw = 0, exp_rv = 0;
  logic [PREG_W-1:0] exp_prd = '0;
  logic [63:0] exp_result = '0, exp_rt = '0;
  logic [RW-1:0] exp_robid = '0;

  // Younger means strictly ahead of the flusher within half the id space.
  function automatic bit yng(input logic [RW-1:0] x, input logic [RW-1:0] f);
    logic [RW-1:0] d;
    d = x - f;
    return (d >= 1) && (d <= (1 << (RW - 1)) - 1);
  endfunction

  // Returns {a_ready, m_ready, a_wins, m_wins} for the current inputs.
  function automatic logic [3:0] model_eval();
    bit ka, km, ea, em, mw, aw;
    ka = flush_valid && yng(a_robid, flush_robid);
    km = flush_valid && yng(m_robid, flush_robid);
    ea = a_valid && !ka;
    em = m_valid && !km;
    mw = em && (!ea || exp_cnt == LIMIT);
    aw = ea && !mw;
    return {(!a_valid || ka || aw), (!m_valid || km || mw), aw, mw};
  endfunction

  task automatic model_reset();
    exp_cnt = 0; exp_valid = 0; exp_src = 0; exp_ntw = 0; exp_rv = 0;
    exp_prd = '0; exp_result = '0; exp_rt = '0; exp_robid = '0;
  endtask

  task automatic tick();
    logic [3:0] r;
    bit em;
    r  = model_eval();
    em = m_valid && !(flush_valid && yng(m_robid, flush_robid));
    exp_valid = r[1] | r[0];
    if (r[0]) begin
      exp_src = 1; exp_ntw = m_need_to_wb; exp_prd = m_prd; exp_result = m_result;
      exp_rv = 0; exp_rt = '0; exp_robid = m_robid;
    end else if (r[1]) begin
      exp_src = 0; exp_ntw = a_need_to_wb; exp_prd = a_prd; exp_result = a_result;
      exp_rv = a_redirect_valid; exp_rt = a_redirect_target; exp_robid = a_robid;
    end else begin
      exp_rv = 0;
    end
    if (em && !r[0]) exp_cnt = (exp_cnt < LIMIT) ? exp_cnt + 1 : LIMIT;
    else exp_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; m_valid = 0; flush_valid = 0;
    a_redirect_valid = 0; a_need_to_wb = 0; m_need_to_wb = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
    n_cmp++; if (starve_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_starve got %0d want 0", starve_cnt); end
    n_cmp++; if ({wb_src, wb_prd, wb_result, wb_robid, wb_redirect_valid} !== '0) begin
      n_bad++; $display("FAIL reset_payload got src=%0b prd=%0d res=%h robid=%0d rv=%0b want all 0",
                        wb_src, wb_prd, wb_result, wb_robid, wb_redirect_valid); end
    @(negedge clk);
    reset_n = 1;
    model_reset();
    @(posedge clk);
    #1;
    $display("reset: wb_valid=%0b starve=%0d", wb_valid, starve_cnt);
  endtask

  task automatic test_a_only();
    idle_inputs();
    a_valid = 1; a_robid = 7'd5; a_prd = 6'd12; a_result = 64'hDEAD; a_need_to_wb = 1;
    @(negedge clk);
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL a_only_ready got %0b want 1", a_ready); end
    tick();
    n_cmp++; if ({wb_valid, wb_src} !== 2'b10) begin n_bad++; $display("FAIL a_only_vs got v=%0b s=%0b want v=1 s=0", wb_valid, wb_src); end
    n_cmp++; if (wb_prd !== 6'd12 || wb_result !== 64'hDEAD) begin
      n_bad++; $display("FAIL a_only_payload got prd=%0d res=%h want prd=12 res=dead", wb_prd, wb_result); end
    $display("a_only: wb_src=%0b prd=%0d result=%h", wb_src, wb_prd, wb_result);
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    int exp_starve [6] = '{1, 2, 3, 4, 0, 1};
    idle_inputs();
    a_valid = 1; a_robid = 7'd20; a_prd = 6'd3; a_result = 64'h11;
    m_valid = 1; m_robid = 7'd15; m_prd = 6'd4; m_result = 64'h22;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (a_ready !== (i != 4) || m_ready !== (i == 4)) begin
        n_bad++; $display("FAIL contention_ready[%0d] got a=%0b m=%0b want a=%0b m=%0b",
                          i, a_ready, m_ready, i != 4, i == 4); end
      tick();
      n_cmp++; if (wb_src !== (i == 4) || wb_valid !== 1'b1) begin
        n_bad++; $display("FAIL contention_src[%0d] got src=%0b v=%0b want src=%0b v=1", i, wb_src, wb_valid, i == 4); end
      n_cmp++; if (starve_cnt !== 3'(exp_starve[i])) begin
        n_bad++; $display("FAIL contention_starve[%0d] got %0d want %0d", i, starve_cnt, exp_starve[i]); end
      $display("contention cycle %0d: wb_src=%0b starve=%0d", i, wb_src, starve_cnt);
    end
  endtask

  task automatic test_flush_kill_a();
    a_valid = 1; m_valid = 1; flush_valid = 1;
    flush_robid = 7'd10; a_robid = 7'd12; m_robid = 7'd8; m_prd = 6'd9; m_result = 64'h77;
    @(negedge clk);
    n_cmp++; if (a_ready !== 1'b1 || m_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_a_ready got a=%0b m=%0b want a=1 m=1", a_ready, m_ready); end
    tick();
    n_cmp++; if (wb_valid !== 1'b1 || wb_src !== 1'b1 || wb_robid !== 7'd8) begin
      n_bad++; $display("FAIL flush_a_wb got v=%0b src=%0b robid=%0d want v=1 src=1 robid=8", wb_valid, wb_src, wb_robid); end
    $display("flush_kill_a: wb_src=%0b robid=%0d", wb_src, wb_robid);
    idle_inputs();
    tick();
  endtask

  task automatic test_wrap();
    a_valid = 1; m_valid = 1; flush_valid = 1;
    flush_robid = {1'b1, 6'd3}; a_robid = {1'b0, 6'd60}; m_robid = {1'b1, 6'd5};
    @(negedge clk);
    n_cmp++; if (a_ready !== 1'b1 || m_ready !== 1'b1) begin
      n_bad++; $display("FAIL wrap_ready got a=%0b m=%0b want a=1 m=1", a_ready, m_ready); end
    tick();
    n_cmp++; if (wb_valid !== 1'b1 || wb_src !== 1'b0 || wb_robid !== {1'b0, 6'd60}) begin
      n_bad++; $display("FAIL wrap_wb got v=%0b src=%0b robid=%0d want v=1 src=0 robid=60", wb_valid, wb_src, wb_robid); end
    n_cmp++; if (starve_cnt !== 3'd0) begin n_bad++; $display("FAIL wrap_starve got %0d want 0", starve_cnt); end
    $display("wrap: wb_src=%0b robid=%0d", wb_src, wb_robid);
    idle_inputs();
    tick();
  endtask

  task automatic test_redirect();
    idle_inputs();
    a_valid = 1; a_robid = 7'd30; a_redirect_valid = 1; a_redirect_target = 64'h8000_1000;
    tick();
    n_cmp++; if (wb_redirect_valid !== 1'b1 || wb_redirect_target !== 64'h8000_1000 || wb_src !== 1'b0) begin
      n_bad++; $display("FAIL redirect_a got rv=%0b tgt=%h src=%0b want rv=1 tgt=80001000 src=0",
                        wb_redirect_valid, wb_redirect_target, wb_src); end
    idle_inputs();
    m_valid = 1; m_robid = 7'd31; m_result = 64'hBEEF;
    tick();
    n_cmp++; if (wb_redirect_valid !== 1'b0 || wb_redirect_target !== 64'd0 || wb_src !== 1'b1) begin
      n_bad++; $display("FAIL redirect_m got rv=%0b tgt=%h src=%0b want rv=0 tgt=0 src=1",
                        wb_redirect_valid, wb_redirect_target, wb_src); end
    idle_inputs();
    tick();
    n_cmp++; if (wb_valid !== 1'b0 || wb_result !== 64'hBEEF) begin
      n_bad++; $display("FAIL redirect_hold got v=%0b res=%h want v=0 res=beef", wb_valid, wb_result); end
    $display("redirect: A redirect then M masked, held result=%h", wb_result);
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    a_valid = 1; m_valid = 1; a_robid = 7'd40; m_robid = 7'd41;
    repeat (3) tick();
    n_cmp++; if (wb_valid !== 1'b1 || starve_cnt !== 3'd3) begin
      n_bad++; $display("FAIL reset_mid_pre got v=%0b starve=%0d want v=1 starve=3", wb_valid, starve_cnt); end
    #2;
    reset_n = 0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0 || starve_cnt !== 3'd0) begin
      n_bad++; $display("FAIL reset_mid_async got v=%0b starve=%0d want v=0 starve=0", wb_valid, starve_cnt); end
    $display("reset_mid: cleared asynchronously v=%0b starve=%0d", wb_valid, starve_cnt);
    idle_inputs();
    @(negedge clk);
    reset_n = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [3:0] r;
    bit a_hold = 0, m_hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!a_hold) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_need_to_wb = 1'($urandom); a_prd = 6'($urandom);
        a_result = {$urandom, $urandom}; a_redirect_valid = ($urandom_range(0, 3) == 0);
        a_redirect_target = {$urandom, $urandom}; a_robid = 7'($urandom);
      end
      if (!m_hold) begin
        m_valid = ($urandom_range(0, 2) != 0);
        m_need_to_wb = 1'($urandom); m_prd = 6'($urandom);
        m_result = {$urandom, $urandom}; m_robid = 7'($urandom);
      end
      flush_valid = ($urandom_range(0, 3) == 0);
      flush_robid = 7'($urandom);
      @(negedge clk);
      r = model_eval();
      n_cmp++; if (a_ready !== r[3] || m_ready !== r[2]) begin
        n_bad++; $display("FAIL rand_ready[%0d] got a=%0b m=%0b want a=%0b m=%0b", i, a_ready, m_ready, r[3], r[2]); end
      n_cmp++; if (starve_cnt !== 3'(exp_cnt)) begin
        n_bad++; $display("FAIL rand_starve[%0d] got %0d want %0d", i, starve_cnt, exp_cnt); end
      a_hold = a_valid && !r[3];
      m_hold = m_valid && !r[2];
      tick();
      n_cmp++; if (wb_valid !== exp_valid || wb_src !== exp_src || wb_need_to_wb !== exp_ntw ||
                   wb_prd !== exp_prd || wb_result !== exp_result || wb_redirect_valid !== exp_rv ||
                   wb_redirect_target !== exp_rt || wb_robid !== exp_robid) begin
        n_bad++; $display("FAIL rand_wb[%0d] got v=%0b s=%0b n=%0b prd=%0d res=%h rv=%0b rt=%h id=%0d want v=%0b s=%0b n=%0b prd=%0d res=%h rv=%0b rt=%h id=%0d",
          i, wb_valid, wb_src, wb_need_to_wb, wb_prd, wb_result, wb_redirect_valid, wb_redirect_target, wb_robid,
          exp_valid, exp_src, exp_ntw, exp_prd, exp_result, exp_rv, exp_rt, exp_robid); end
      if (exp_valid) $display("rand %0d: wb src=%0b robid=%0d prd=%0d", i, wb_src, wb_robid, wb_prd);
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_a_only();
    test_contention();
    test_flush_kill_a();
    test_wrap();
    test_redirect();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
